// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a multi-beat
// line refill, misalignment reporting and a sequential whole-cache flush.
module dcache_dm #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        width_i,
  input  logic              zext_i,
  input  logic [31:0]       data_in_i,
  output logic              valid_o,
  output logic              err_o,
  output logic [31:0]       data_out_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i
);
  localparam int WORD_W = $clog2(WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BEAT_W = (WORDS > 1) ? WORD_W : 1;
  localparam int SLOT_W = $clog2(LINES * WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d, zext_q, zext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          width_q, width_d;
  logic [31:0]         wdat_q, wdat_d, load_word_q, load_word_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]    fcnt_q, fcnt_d;
  logic [LINES-1:0]    vbits_q, vbits_d;
  logic                valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [31:0]         data_out_q, data_out_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];

  logic                data_we, tag_we, hit, bad;
  logic [SLOT_W-1:0]   data_slot;
  logic [31:0]         data_wdata, merged;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic [BEAT_W-1:0]   word;
  logic [ADDR_W-1:0]   line_base;

  function automatic logic [SLOT_W-1:0] slot(input logic [IDX_W-1:0] idx, input logic [BEAT_W-1:0] w);
    return SLOT_W'(int'(idx) * WORDS + int'(w));
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lo,
                                         input logic [1:0] wd, input logic z);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (wd)
      2'b00:   return z ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return z ? {16'h0, h} : {{16{h[15]}}, h};
      2'b10:   return w;
      default: return '0;
    endcase
  endfunction

  assign index     = addr_q[OFF_W +: IDX_W];
  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign word      = BEAT_W'((addr_q >> 2) & ADDR_W'(WORDS - 1));
  assign line_base = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign hit       = vbits_q[index] && (tag_mem[index] == tag);
  assign bad       = (width_q == 2'b11) || (width_q == 2'b01 && addr_q[0]) ||
                     (width_q == 2'b10 && addr_q[1:0] != 2'b00);

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;     we_d        = we_q;        zext_d      = zext_q;
    addr_d      = addr_q;      width_d     = width_q;     wdat_d      = wdat_q;
    load_word_d = load_word_q; beat_d      = beat_q;      fcnt_d      = fcnt_q;
    vbits_d     = vbits_q;     data_out_d  = data_out_q;  mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;    mem_addr_d  = mem_addr_q;  mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    data_slot   = slot(index, word);
    merged      = data_mem[data_slot];
    for (int i = 0; i < 4; i++)
      if (mem_wstrb_q[i]) merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
    data_wdata  = merged;

    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          fcnt_d  = '0;
          state_d = S_FLUSH;
        end else if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          width_d = width_i;
          zext_d  = zext_i;
          wdat_d  = data_in_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (bad) begin
          valid_d    = 1'b1;
          err_d      = 1'b1;
          data_out_d = '0;
          state_d    = S_RESP;
        end else if (!we_q && hit) begin
          valid_d    = 1'b1;
          data_out_d = extend(data_mem[data_slot], addr_q[1:0], width_q, zext_q);
          state_d    = S_RESP;
        end else if (!we_q) begin
          beat_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = line_base;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          state_d     = S_REFILL;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
          case (width_q)
            2'b00:   begin mem_wdata_d = {4{wdat_q[7:0]}};  mem_wstrb_d = 4'b0001 << addr_q[1:0]; end
            2'b01:   begin mem_wdata_d = {2{wdat_q[15:0]}}; mem_wstrb_d = addr_q[1] ? 4'b1100 : 4'b0011; end
            default: begin mem_wdata_d = wdat_q;            mem_wstrb_d = 4'b1111; end
          endcase
          state_d = S_WRITE;
        end
      end
      S_REFILL: begin
        if (mem_ready_i) begin
          data_we    = 1'b1;
          data_slot  = slot(index, beat_q);
          data_wdata = mem_rdata_i;
          if (beat_q == word) load_word_d = mem_rdata_i;
          if (beat_q == BEAT_W'(WORDS - 1)) begin
            tag_we         = 1'b1;
            vbits_d[index] = 1'b1;
            mem_req_d      = 1'b0;
            mem_addr_d     = '0;
            valid_d        = 1'b1;
            data_out_d     = extend((beat_q == word) ? mem_rdata_i : load_word_q,
                                    addr_q[1:0], width_q, zext_q);
            state_d        = S_RESP;
          end else begin
            beat_d     = beat_q + 1'b1;
            mem_addr_d = line_base + ((ADDR_W'(beat_q) + 1) << 2);
          end
        end
      end
      S_WRITE: begin
        if (mem_ready_i) begin
          data_we     = hit;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          valid_d     = 1'b1;
          data_out_d  = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        data_out_d = '0;
        state_d    = S_IDLE;
      end
      S_FLUSH: begin
        vbits_d[fcnt_q] = 1'b0;
        if (fcnt_q == IDX_W'(LINES - 1)) state_d = S_IDLE;
        else                              fcnt_d  = fcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;  we_q <= 1'b0;  zext_q <= 1'b0;  addr_q <= '0;  width_q <= '0;
      wdat_q <= '0;  load_word_q <= '0;  beat_q <= '0;  fcnt_q <= '0;  vbits_q <= '0;
      valid_q <= 1'b0;  err_q <= 1'b0;  busy_q <= 1'b0;  data_out_q <= '0;
      mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q <= state_d;  we_q <= we_d;  zext_q <= zext_d;  addr_q <= addr_d;  width_q <= width_d;
      wdat_q <= wdat_d;  load_word_q <= load_word_d;  beat_q <= beat_d;  fcnt_q <= fcnt_d;
      vbits_q <= vbits_d;  valid_q <= valid_d;  err_q <= err_d;  busy_q <= busy_d;
      data_out_q <= data_out_d;  mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;  mem_wdata_q <= mem_wdata_d;  mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone say which lines are live.
  always_ff @(posedge clk) begin
    if (rst_n && data_we) data_mem[data_slot] <= data_wdata;
    if (rst_n && tag_we)  tag_mem[index]      <= tag;
  end

  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign data_out_o  = data_out_q;
  assign busy_o      = busy_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a word-wide memory responder with optional wait
// states, and a linear sequence of loads, stores, errors, flush and reset.
module tb_dcache_dm;
  logic        clk = 1'b0;
  logic        rst_n, req_i, we_i, zext_i, flush_i, mem_ready_i;
  logic [31:0] addr_i, data_in_i, mem_rdata_i;
  logic [1:0]  width_i;
  logic        valid_o, err_o, busy_o, mem_req_o, mem_we_o;
  logic [31:0] data_out_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;

  dcache_dm #(.ADDR_W(32), .LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .width_i(width_i), .zext_i(zext_i), .data_in_i(data_in_i), .valid_o(valid_o),
    .err_o(err_o), .data_out_o(data_out_o), .flush_i(flush_i), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  int nrd, nwr, wait_cyc = 0, wcnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  logic        pend = 1'b0, p_we;
  logic [31:0] p_addr, p_wdata, last_wdata, last_waddr;
  logic [3:0]  p_strb, last_wstrb;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory side: decide readiness mid-cycle, commit the beat at the clock edge.
  always @(negedge clk) begin
    pend        = 1'b0;
    mem_ready_i = 1'b0;
    if (mem_req_o) begin
      if (wcnt < wait_cyc) wcnt++;
      else begin
        wcnt        = 0;
        mem_ready_i = 1'b1;
        mem_rdata_i = rd(mem_addr_o);
        pend = 1'b1; p_we = mem_we_o; p_addr = mem_addr_o; p_wdata = mem_wdata_o; p_strb = mem_wstrb_o;
      end
    end
  end

  always @(posedge clk) begin
    if (pend && rst_n) begin
      if (p_we) begin
        logic [31:0] w;
        w = rd(p_addr);
        for (int i = 0; i < 4; i++) if (p_strb[i]) w[8*i +: 8] = p_wdata[8*i +: 8];
        mem[p_addr] = w;
        nwr++;
        last_wdata = p_wdata; last_wstrb = p_strb; last_waddr = p_addr;
      end else begin
        nrd++;
        rd_log.push_back(p_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input logic we, input logic [31:0] a, input logic [1:0] w,
                           input logic z, input logic [31:0] d,
                           output logic [31:0] dout, output logic e, output int cyc);
    nrd = 0; nwr = 0; rd_log.delete();
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = a; width_i = w; zext_i = z; data_in_i = d;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!valid_o && cyc < 200);
    check("valid_arrives", {31'b0, valid_o}, 32'd1);
    dout = data_out_o; e = err_o;
    req_i = 1'b0;
    @(posedge clk); #1;
    check("valid_one_cycle", {31'b0, valid_o}, 32'd0);
  endtask

  logic [31:0] dout;
  logic        e;
  int          cyc, n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; zext_i = 1'b0; flush_i = 1'b0;
    addr_i = '0; data_in_i = '0; width_i = 2'b10; mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      mem[32'h1000_0040 + 4*i] = 32'h1111_1111 * (i + 1);
      mem[32'h1000_0440 + 4*i] = 32'h5555_5555 + 32'h1111_1111 * i;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_data_out", data_out_o, 32'd0);
    check("rst_mem_addr_strb", {mem_addr_o[27:0], mem_wstrb_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Cold miss refills the full line in ascending order.
    do_access(1'b0, 32'h1000_0040, 2'b10, 1'b0, 0, dout, e, cyc);
    check("lw_miss_data", dout, 32'h1111_1111);
    check("lw_miss_beats", nrd, 4);
    check("lw_miss_latency", cyc, 6);
    for (int i = 0; i < 4; i++)
      check("refill_addr", (rd_log.size() > i) ? rd_log[i] : 32'hFFFF_FFFF, 32'h1000_0040 + 4*i);
    do_access(1'b0, 32'h1000_0048, 2'b10, 1'b0, 0, dout, e, cyc);
    check("lw_hit_data", dout, 32'h3333_3333);
    check("lw_hit_nomem", nrd + nwr, 0);
    check("lw_hit_latency", cyc, 2);

    // Word store on a hit: write-through plus array update.
    do_access(1'b1, 32'h1000_0040, 2'b10, 1'b0, 32'h8001_7FF0, dout, e, cyc);
    check("sw_writes", nwr, 1);
    check("sw_strb", {28'b0, last_wstrb}, 32'hF);
    check("sw_latency", cyc, 3);
    check("sw_data_out", dout, 32'd0);

    do_access(1'b0, 32'h1000_0040, 2'b00, 1'b0, 0, dout, e, cyc);
    check("lb_sext", dout, 32'hFFFF_FFF0);
    do_access(1'b0, 32'h1000_0040, 2'b00, 1'b1, 0, dout, e, cyc);
    check("lbu", dout, 32'h0000_00F0);
    do_access(1'b0, 32'h1000_0042, 2'b01, 1'b0, 0, dout, e, cyc);
    check("lh_sext", dout, 32'hFFFF_8001);
    do_access(1'b0, 32'h1000_0042, 2'b01, 1'b1, 0, dout, e, cyc);
    check("lhu", dout, 32'h0000_8001);
    check("lhu_nomem", nrd, 0);

    // Byte store replicates data and strobes one lane.
    do_access(1'b1, 32'h1000_0041, 2'b00, 1'b0, 32'h0000_00AB, dout, e, cyc);
    check("sb_strb", {28'b0, last_wstrb}, 32'h2);
    check("sb_wdata", last_wdata, 32'hABAB_ABAB);
    check("sb_waddr", last_waddr, 32'h1000_0040);
    do_access(1'b0, 32'h1000_0040, 2'b10, 1'b0, 0, dout, e, cyc);
    check("sb_merged", dout, 32'h8001_ABF0);
    check("sb_merged_nomem", nrd, 0);

    // Misaligned and illegal-width accesses.
    do_access(1'b0, 32'h1000_0042, 2'b10, 1'b0, 0, dout, e, cyc);
    check("lw_mis_err", {31'b0, e}, 32'd1);
    check("lw_mis_data", dout, 32'd0);
    check("lw_mis_latency", cyc, 2);
    do_access(1'b1, 32'h1000_0041, 2'b01, 1'b0, 32'hDEAD_BEEF, dout, e, cyc);
    check("sh_mis_err", {31'b0, e}, 32'd1);
    check("sh_mis_nomem", nrd + nwr, 0);
    do_access(1'b0, 32'h1000_0040, 2'b11, 1'b0, 0, dout, e, cyc);
    check("w11_err", {31'b0, e}, 32'd1);
    check("w11_nomem", nrd + nwr, 0);
    do_access(1'b0, 32'h1000_0040, 2'b10, 1'b0, 0, dout, e, cyc);
    check("after_err_data", dout, 32'h8001_ABF0);
    check("after_err_err", {31'b0, e}, 32'd0);

    // Conflict eviction with one wait state per beat.
    wait_cyc = 1;
    do_access(1'b0, 32'h1000_0440, 2'b10, 1'b0, 0, dout, e, cyc);
    check("evict_data", dout, 32'h5555_5555);
    check("evict_beats", nrd, 4);
    check("evict_latency", cyc, 10);
    do_access(1'b0, 32'h1000_0040, 2'b10, 1'b0, 0, dout, e, cyc);
    check("reload_beats", nrd, 4);
    check("reload_data", dout, 32'h8001_ABF0);
    wait_cyc = 0;

    // Flush: busy for one cycle per line, then the line misses.
    @(negedge clk); flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin n++; @(posedge clk); #1; end
    check("flush_busy_cycles", n, 16);
    do_access(1'b0, 32'h1000_0040, 2'b10, 1'b0, 0, dout, e, cyc);
    check("post_flush_beats", nrd, 4);

    // Store miss: one memory write, no allocation.
    do_access(1'b1, 32'h1000_0080, 2'b10, 1'b0, 32'h1234_5678, dout, e, cyc);
    check("sw_miss_writes", nwr, 1);
    check("sw_miss_reads", nrd, 0);
    check("sw_miss_latency", cyc, 3);
    do_access(1'b0, 32'h1000_0080, 2'b10, 1'b0, 0, dout, e, cyc);
    check("sw_miss_noalloc", nrd, 4);
    check("sw_miss_readback", dout, 32'h1234_5678);

    // Reset in the middle of a refill.
    nrd = 0; rd_log.delete();
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1000_00C0; width_i = 2'b10; zext_i = 1'b0;
    n = 0;
    while (nrd < 2 && n < 50) begin @(posedge clk); #1; n++; end
    check("mid_refill_beats", nrd, 2);
    @(negedge clk); rst_n = 1'b0; req_i = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_mem_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_access(1'b0, 32'h1000_00C0, 2'b10, 1'b0, 0, dout, e, cyc);
    check("rerefill_beats", nrd, 4);
    check("rerefill_latency", cyc, 6);
    check("rerefill_data", dout, 32'hB5A5_00C0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised, direct-mapped, write-through, no-write-allocate data cache.
- Sits between the core's memory-access stage and a word-wide memory port, replacing the stub data cache.
- Supports byte, halfword and word loads and stores, and sign or zero extension on loads.
- Adds a multi-beat line refill, memory handshake, misalignment error reporting and a whole-cache flush.

Parameters:
ADDR_W  32  address and data width in bits; fixed at 32 for RV32.
LINES  16  number of cache lines; power of two, at least 2.
WORDS  4  32-bit words per line; power of two, at least 1.

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous reset, active low.
req  in  1  CPU request; held high with stable fields until valid.
we  in  1  1 = store, 0 = load.
addr  in  32  byte address.
width  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
zext  in  1  load extension: 1 = zero-extend, 0 = sign-extend (funct3[2]).
data_in  in  32  store data, LSB-aligned.
valid  out  1  one-cycle completion pulse.
err  out  1  qualifies valid: misaligned access or illegal width.
data_out  out  32  extended load data; valid only with valid=1 and we=0.
flush  in  1  single-cycle pulse: invalidate all lines.
busy  out  1  high in every state other than IDLE.
mem_req  out  1  memory request.
mem_we  out  1  memory write.
mem_addr  out  32  word-aligned memory address.
mem_wdata  out  32  lane-aligned write data.
mem_wstrb  out  4  byte-lane strobes.
mem_ready  in  1  beat completes on a cycle where mem_req=1 and mem_ready=1.
mem_rdata  in  32  read data, sampled in the completing cycle.

Behaviour:
- Address split:
  - offset = addr[log2(WORDS)+1:0]
  - index = next log2(LINES) bits
  - tag = remaining upper bits.
- Storage:
  - tag and data arrays with no reset.
  - one valid bit per line, cleared by reset.
- Reset (rst_n=0 at a clock edge):
  - state becomes IDLE; all valid bits are cleared.
  - valid, err, data_out, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata all 0.
  - any in-flight memory beat is abandoned.
- All outputs are registered.
- States: IDLE, LOOKUP, REFILL, WRITE, RESP, FLUSH.
- IDLE:
  - flush=1 goes to FLUSH; flush takes priority over a simultaneous req.
  - otherwise req=1 latches we, addr, width, zext, data_in and goes to LOOKUP.
- LOOKUP:
  - Misalignment is an odd address with width=01, or addr[1:0]≠0 with width=10. Misaligned access or width=11 goes to RESP with err=1 and no memory or array side effects.
  - Load hit goes to RESP.
  - Load miss goes to REFILL, beat counter = 0.
  - Store (hit or miss) goes to WRITE.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, index, beat, 2'b00}, beats ascending from 0 to WORDS-1.
  - Each completing beat writes mem_rdata into the data array.
  - After the last beat: write the tag, set the valid bit, go to RESP.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = addr word-aligned.
  - mem_wdata = data_in replicated into the lanes: byte into all four, half into both.
  - mem_wstrb: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
  - On mem_ready: if the line hits, merge the strobed bytes into the array (no-write-allocate on a miss); go to RESP.
- RESP:
  - valid=1 for exactly one cycle.
  - data_out = selected byte or half, extended per zext; word passes through; 0 for stores and errors.
  - Return to IDLE.
- Latency from req sampled in IDLE:
  - load hit or error: valid 2 cycles later.
  - miss: 2 + WORDS + memory wait cycles.
  - store: 2 + 1 + memory wait cycles.
- A new req is not accepted in the cycle valid is high; the earliest acceptance is the following IDLE cycle.
- FLUSH:
  - clears one valid bit per cycle, index 0 to LINES-1 (LINES cycles), then IDLE.
  - flush pulses arriving while busy are ignored.
- mem_req stays asserted with stable address, data and strobes until mem_ready.

Test Plan:
1. Reset, then LW 0x10000040: 4 reads at 0x40, 0x44, 0x48, 0x4C returning 0x11111111..0x44444444 -> data_out=0x11111111. Repeat LW 0x10000048 -> no mem_req, data_out=0x33333333, valid 2 cycles after req.
2. Line holds 0x80017FF0 at 0x10000040:
   - LB +0 zext=0 -> 0xFFFFFFF0; zext=1 -> 0x000000F0.
   - LH +2 zext=0 -> 0xFFFF8001.
   - LHU +2 -> 0x00008001.
3. SB 0xAB to 0x10000041 on a hit -> mem_wstrb=0010, mem_wdata=0xABABABAB; then LW 0x10000040 returns 0x8001ABF0 without a refill.
4. LW 0x10000042, LH 0x10000041, width=11 -> each gives valid=1, err=1, no mem_req, cache unchanged.
5. LINES=16, WORDS=4:
   - LW 0x10000040 then LW 0x10000440 (same index) -> second refills and evicts the first; reloading 0x10000040 misses.
   - flush -> busy for 16 cycles, then every access misses.
   - SW miss -> one memory write, a following load still refills.
6. rst_n=0 after 2 refill beats -> mem_req=0 next cycle, state IDLE; re-request of the same address performs a full 4-beat refill.
